thermo_display_ctrl: RTL and testbench

Parametrised thermostat front-end: holds independent °F and °C setpoints adjusted by debounced up/down buttons with auto-repeat and saturation, drives heat/cool outputs through a hysteresis state machine, and multiplexes an 8-digit active-low seven-segment display. It sits between the temperature-sensor converter (which supplies `temp_c`/`temp_f`) and the board LEDs and display pins.

---
 rtl/thermo_pkg.sv | 67 ++++++
 rtl/btn_debounce.sv | 73 +++++++
 rtl/thermo_display_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_thermo_display_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared types and glyph constants for the thermostat front-end.
// Glyphs are active-low, {a,b,c,d,e,f,g} in bits [6:0].
package thermo_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h01;
    localparam logic [6:0] GLYPH_1     = 7'h4F;
    localparam logic [6:0] GLYPH_2     = 7'h12;
    localparam logic [6:0] GLYPH_3     = 7'h06;
    localparam logic [6:0] GLYPH_4     = 7'h4C;
    localparam logic [6:0] GLYPH_5     = 7'h24;
    localparam logic [6:0] GLYPH_6     = 7'h20;
    localparam logic [6:0] GLYPH_7     = 7'h0F;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h04;
    localparam logic [6:0] GLYPH_C     = 7'h31;
    localparam logic [6:0] GLYPH_F     = 7'h38;
    localparam logic [6:0] GLYPH_DEG   = 7'h1C;
    localparam logic [6:0] GLYPH_DASH  = 7'h7E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAT,
        ST_COOL
    } state_t;

    typedef enum logic [2:0] {
        SC_UNIT,
        SC_DEG,
        SC_T_ONES,
        SC_T_TENS,
        SC_SP_ONES,
        SC_SP_TENS
    } slot_t;

    function automatic slot_t slot_of(input logic [2:0] idx);
        slot_t s;
        case (idx)
            3'd0, 3'd4: s = SC_UNIT;
            3'd1, 3'd5: s = SC_DEG;
            3'd2:       s = SC_T_ONES;
            3'd3:       s = SC_T_TENS;
            3'd6:       s = SC_SP_ONES;
            default:    s = SC_SP_TENS;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, stability debounce, edge step and
// auto-repeat. hold suppresses steps and parks the repeat timer.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned RPT_DELAY  = 50000000,
    parameter int unsigned RPT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic hold,
    output logic level,
    output logic step_pulse
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RW = $clog2(RPT_DELAY + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RPT_FIRE = RW'(RPT_DELAY);
    localparam logic [RW-1:0] RPT_LOAD = RW'(RPT_DELAY - RPT_PERIOD + 1);

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rpt_cnt;

    // Two-stage synchroniser for the raw asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            deb_cnt <= '0;
        end else if (sync2 == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            level   <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Repeat timer: counts while held, reloads so later fires are RPT_PERIOD apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            level_q <= level;
            if (!level || hold) begin
                rpt_cnt <= '0;
            end else if (rpt_cnt == RPT_FIRE) begin
                rpt_cnt <= RPT_LOAD;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    assign step_pulse = level & ~hold & (~level_q | (rpt_cnt == RPT_FIRE));

endmodule

// File: rtl/thermo_display_ctrl.sv
// Thermostat front-end: setpoints, hysteresis heat/cool control and
// an 8-digit multiplexed seven-segment display.
import thermo_pkg::*;

module thermo_display_ctrl #(
    parameter int TW         = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 250000,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 10000000,
    parameter int HYST       = 1,
    parameter int SPF_INIT   = 80,
    parameter int SPF_MIN    = 40,
    parameter int SPF_MAX    = 99,
    parameter int SPC_INIT   = 15,
    parameter int SPC_MIN    = 5,
    parameter int SPC_MAX    = 37
) (
    input  logic          main_clk,
    input  logic          rst_n,
    input  logic          unit_sel,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic [TW-1:0] temp_c,
    input  logic [TW-1:0] temp_f,
    output logic          heat,
    output logic          cool,
    output logic [6:0]    seg,
    output logic [7:0]    an
);

    localparam int TW1 = TW + 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [TW:0]    HYST_W    = TW1'(HYST);
    localparam logic [TW-1:0]  SPF_LO    = TW'(SPF_MIN);
    localparam logic [TW-1:0]  SPF_HI    = TW'(SPF_MAX);
    localparam logic [TW-1:0]  SPC_LO    = TW'(SPC_MIN);
    localparam logic [TW-1:0]  SPC_HI    = TW'(SPC_MAX);

    logic           up_level, up_step;
    logic           dn_level, dn_step;
    logic           both;
    logic [TW-1:0]  spf, spc;
    logic [TW-1:0]  sp, t;
    logic [TW:0]    sp_w, t_w;
    logic           unit_q;
    state_t         state;
    logic [SCW-1:0] scan_cnt;
    logic [2:0]     idx;
    logic           load;
    logic [6:0]     seg_next;
    logic [13:0]    t_pair, sp_pair;

    assign both = up_level & dn_level;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_up (
        .clk        (main_clk),
        .rst_n      (rst_n),
        .btn        (btn_up),
        .hold       (both),
        .level      (up_level),
        .step_pulse (up_step)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_dn (
        .clk        (main_clk),
        .rst_n      (rst_n),
        .btn        (btn_down),
        .hold       (both),
        .level      (dn_level),
        .step_pulse (dn_step)
    );

    assign sp   = unit_sel ? spc : spf;
    assign t    = unit_sel ? temp_c : temp_f;
    assign sp_w = {1'b0, sp};
    assign t_w  = {1'b0, t};

    // Saturating step of the active unit's setpoint; inactive one is kept.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            spf <= TW'(SPF_INIT);
            spc <= TW'(SPC_INIT);
        end else if (unit_sel) begin
            if (up_step && spc < SPC_HI) begin
                spc <= spc + 1'b1;
            end else if (dn_step && spc > SPC_LO) begin
                spc <= spc - 1'b1;
            end
        end else begin
            if (up_step && spf < SPF_HI) begin
                spf <= spf + 1'b1;
            end else if (dn_step && spf > SPF_LO) begin
                spf <= spf - 1'b1;
            end
        end
    end

    // Hysteresis FSM with registered heat/cool; a unit change forces IDLE.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            heat   <= 1'b0;
            cool   <= 1'b0;
            unit_q <= 1'b0;
        end else begin
            unit_q <= unit_sel;
            if (unit_sel != unit_q) begin
                state <= ST_IDLE;
                heat  <= 1'b0;
                cool  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (t_w + HYST_W < sp_w) begin
                            state <= ST_HEAT;
                            heat  <= 1'b1;
                        end else if (t_w > sp_w + HYST_W) begin
                            state <= ST_COOL;
                            cool  <= 1'b1;
                        end
                    end
                    ST_HEAT: begin
                        if (t_w >= sp_w) begin
                            state <= ST_IDLE;
                            heat  <= 1'b0;
                        end
                    end
                    ST_COOL: begin
                        if (t_w <= sp_w) begin
                            state <= ST_IDLE;
                            cool  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        heat  <= 1'b0;
                        cool  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Slot timer; load marks the cycle after the digit index moved.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            load     <= 1'b0;
        end else begin
            load <= 1'b0;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 1'b1;
                load     <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    function automatic logic [13:0] render_pair(input logic [TW-1:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / TW'(10));
        ones = 4'(v % TW'(10));
        if (v > TW'(99)) begin
            return {GLYPH_DASH, GLYPH_DASH};
        end
        return {(tens == 4'd0) ? GLYPH_BLANK : digit_glyph(tens),
                digit_glyph(ones)};
    endfunction

    assign t_pair  = render_pair(t);
    assign sp_pair = render_pair(sp);

    // Pick the glyph for the current slot.
    always_comb begin
        seg_next = GLYPH_BLANK;
        unique case (slot_of(idx))
            SC_UNIT:    seg_next = unit_sel ? GLYPH_C : GLYPH_F;
            SC_DEG:     seg_next = GLYPH_DEG;
            SC_T_ONES:  seg_next = t_pair[6:0];
            SC_T_TENS:  seg_next = t_pair[13:7];
            SC_SP_ONES: seg_next = sp_pair[6:0];
            SC_SP_TENS: seg_next = sp_pair[13:7];
            default:    seg_next = GLYPH_BLANK;
        endcase
    end

    // an and seg move together once per slot so a slot never mixes indices.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 8'hFF;
            seg <= GLYPH_BLANK;
        end else if (load) begin
            an  <= ~(8'b1 << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_thermo_display_ctrl.sv
// Randomised bench for thermo_display_ctrl against a behavioural model.
// Short timing parameters keep button and scan behaviour visible.
module tb_thermo_display_ctrl;

    localparam int S   = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int HY  = 1;

    logic       clk;
    logic       rst_n;
    logic       unit_sel;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] temp_c;
    logic [7:0] temp_f;
    logic       heat;
    logic       cool;
    logic [6:0] seg;
    logic [7:0] an;

    int vectors;
    int errors;

    thermo_display_ctrl #(
        .SCAN_DIV   (S),
        .DEB_CYCLES (DEB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .main_clk (clk),
        .rst_n    (rst_n),
        .unit_sel (unit_sel),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .temp_c   (temp_c),
        .temp_f   (temp_f),
        .heat     (heat),
        .cool     (cool),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lit segments, active high, abcdefg: 0-9, C, F, degree, dash, blank.
    logic [6:0] pat [15] = '{7'b1111110, 7'b0110000, 7'b1101101,
                             7'b1111001, 7'b0110011, 7'b1011011,
                             7'b1011111, 7'b1110000, 7'b1111111,
                             7'b1111011, 7'b1001110, 7'b1000111,
                             7'b1100011, 7'b0000001, 7'b0000000};

    int         k;
    int         m_spf, m_spc, m_state;
    bit         m_uq;
    logic [7:0] m_an;
    logic [6:0] m_seg;
    bit         rp [2][2];
    bit         lvl [2];
    bit         plv [2];
    int         h [2];
    bit         sq0 [$];
    bit         sq1 [$];

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int g);
        return ~pat[g];
    endfunction

    function automatic logic [6:0] digit_seg(input int v, input bit tens);
        if (v > 99) return glyph(13);
        if (tens) return (v / 10 == 0) ? glyph(14) : glyph(v / 10);
        return glyph(v % 10);
    endfunction

    function automatic logic [6:0] render(input int idx, input bit usel,
                                          input int tv, input int spv);
        case (idx)
            0, 4:    return glyph(usel ? 10 : 11);
            1, 5:    return glyph(12);
            2:       return digit_seg(tv, 1'b0);
            3:       return digit_seg(tv, 1'b1);
            6:       return digit_seg(spv, 1'b0);
            default: return digit_seg(spv, 1'b1);
        endcase
    endfunction

    function automatic bit window_flip(input bit q[$], input bit l);
        if (q.size() < DEB) return 1'b0;
        for (int i = q.size() - DEB; i < q.size(); i++)
            if (q[i] == l) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        k = 0;
        m_spf = 80;
        m_spc = 15;
        m_state = 0;
        m_uq = 1'b0;
        m_an = 8'hFF;
        m_seg = 7'h7F;
        for (int b = 0; b < 2; b++) begin
            rp[b][0] = 1'b0;
            rp[b][1] = 1'b0;
            lvl[b] = 1'b0;
            plv[b] = 1'b0;
            h[b] = 0;
        end
        sq0.delete();
        sq1.delete();
    endtask

    task automatic model_step();
        bit         both;
        bit         st [2];
        bit         s [2];
        bit         nl [2];
        int         sp, tv, idx;
        logic [7:0] one;
        one = 8'd1;
        sp = unit_sel ? m_spc : m_spf;
        tv = unit_sel ? int'(temp_c) : int'(temp_f);
        both = lvl[0] & lvl[1];
        for (int b = 0; b < 2; b++)
            st[b] = !both && lvl[b] &&
                    (!plv[b] || (h[b] >= RD && (h[b] - RD) % RP == 0));
        k++;
        if (k > 1 && (k - 1) % S == 0) begin
            idx = ((k - 1) / S) % 8;
            m_an = ~(one << idx);
            m_seg = render(idx, unit_sel, tv, sp);
        end
        if (unit_sel != m_uq) m_state = 0;
        else case (m_state)
            0: if (tv + HY < sp) m_state = 1;
               else if (tv > sp + HY) m_state = 2;
            1: if (tv >= sp) m_state = 0;
            default: if (tv <= sp) m_state = 0;
        endcase
        m_uq = unit_sel;
        if (unit_sel) begin
            if (st[0]) m_spc = (m_spc < 37) ? m_spc + 1 : 37;
            else if (st[1]) m_spc = (m_spc > 5) ? m_spc - 1 : 5;
        end else begin
            if (st[0]) m_spf = (m_spf < 99) ? m_spf + 1 : 99;
            else if (st[1]) m_spf = (m_spf > 40) ? m_spf - 1 : 40;
        end
        for (int b = 0; b < 2; b++) begin
            s[b] = rp[b][0];
            rp[b][0] = rp[b][1];
            rp[b][1] = (b == 0) ? btn_up : btn_down;
        end
        sq0.push_back(s[0]);
        if (sq0.size() > DEB) void'(sq0.pop_front());
        sq1.push_back(s[1]);
        if (sq1.size() > DEB) void'(sq1.pop_front());
        nl[0] = window_flip(sq0, lvl[0]) ? ~lvl[0] : lvl[0];
        nl[1] = window_flip(sq1, lvl[1]) ? ~lvl[1] : lvl[1];
        for (int b = 0; b < 2; b++) begin
            h[b] = (!lvl[b] || both) ? 0 : h[b] + 1;
            plv[b] = lvl[b];
            lvl[b] = nl[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        expect_eq("heat", {31'd0, heat}, {31'd0, m_state == 1});
        expect_eq("cool", {31'd0, cool}, {31'd0, m_state == 2});
        expect_eq("an", {24'd0, an}, {24'd0, m_an});
        expect_eq("seg", {25'd0, seg}, {25'd0, m_seg});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        expect_eq({tag, "_an"}, {24'd0, an}, 32'hFF);
        expect_eq({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        expect_eq({tag, "_heat"}, {31'd0, heat}, 32'd0);
        expect_eq({tag, "_cool"}, {31'd0, cool}, 32'd0);
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        rst_n = 1'b0;
        unit_sel = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        temp_f = 8'd80;
        temp_c = 8'd15;
        #23;
        check_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run(10);
        temp_f = 8'd70;
        run(5);
        temp_f = 8'd79;
        run(5);
        temp_f = 8'd80;
        run(8);

        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        tick();
        btn_up = 1'b1;
        run(30);
        btn_up = 1'b0;
        run(20);

        unit_sel = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn_up = 1'b1;
            run(8);
            btn_up = 1'b0;
            run(8);
        end
        btn_down = 1'b1;
        run(220);
        btn_down = 1'b0;
        run(15);

        btn_up = 1'b1;
        btn_down = 1'b1;
        run(60);
        btn_down = 1'b0;
        run(40);
        btn_up = 1'b0;
        run(15);

        unit_sel = 1'b0;
        temp_f = 8'd50;
        run(6);
        unit_sel = 1'b1;
        temp_c = 8'd30;
        run(6);

        unit_sel = 1'b0;
        temp_f = 8'd120;
        run(70);
        temp_f = 8'd5;
        run(70);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int seg_i = 0; seg_i < 160; seg_i++) begin
            int len;
            len = $urandom_range(1, 50);
            if ($urandom_range(0, 7) == 0) unit_sel = ~unit_sel;
            temp_f = 8'($urandom_range(30, 120));
            temp_c = 8'($urandom_range(0, 45));
            if ($urandom_range(0, 9) == 0) temp_f = 8'($urandom);
            for (int c = 0; c < len; c++) begin
                if (c < 3) begin
                    btn_up = 1'($urandom);
                    btn_down = ($urandom_range(0, 3) == 0);
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
